// File: rtl/tetris_pkg.sv
// Shared types and constants for the Tetris input-conditioning stage.
// Channel indices fix the bit order of the held vector: {drop, rot, right, left}.
package tetris_pkg;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_e;

    localparam int CH_LEFT  = 0;
    localparam int CH_RIGHT = 1;
    localparam int CH_ROT   = 2;
    localparam int CH_DROP  = 3;
    localparam int NUM_KEYS = 4;

    localparam int DEBOUNCE_CYCLES_50M = 1_000_000;
    localparam int DAS_DELAY_50M       = 8_000_000;
    localparam int DAS_RATE_50M        = 2_500_000;

    // The extra bit keeps the terminal value representable for any count.
    function automatic int cnt_width(input int a, input int b);
        return $clog2((a > b) ? a : b) + 1;
    endfunction

endpackage

// File: rtl/tetris_input_cond_key_debounce.sv
// One key channel: 2-FF synchronizer, stable-level counter, registered
// debounced level and a one-cycle rise flag aligned with the level change.
module key_debounce
    import tetris_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50M,
    parameter int KEY_ACTIVE_LOW  = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic key_raw,
    output logic level,
    output logic rise
);

    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES, 1);
    localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic          RAW_IDLE = (KEY_ACTIVE_LOW != 0);

    logic          sync1;
    logic          sync2;
    logic          pressed;
    logic [CW-1:0] cnt;

    assign pressed = sync2 ^ RAW_IDLE;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= RAW_IDLE;
            sync2 <= RAW_IDLE;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
            rise  <= 1'b0;
            // Any cycle agreeing with the current level restarts the stability count.
            if (pressed == level) begin
                cnt <= '0;
            end else if (cnt == DB_LAST) begin
                level <= pressed;
                rise  <= pressed;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tetris_input_cond.sv
// Turns raw DE1 keys into single-cycle game action pulses with delayed
// auto-shift on left/right/drop, a left/right lockout and an enable gate.
module tetris_input_cond
    import tetris_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50M,
    parameter int DAS_DELAY       = DAS_DELAY_50M,
    parameter int DAS_RATE        = DAS_RATE_50M,
    parameter int KEY_ACTIVE_LOW  = 1
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       enable,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_rot,
    input  logic       key_drop,
    output logic       left_final,
    output logic       right_final,
    output logic       rot_final,
    output logic       drop_final,
    output logic [3:0] held
);

    localparam int            CW        = cnt_width(DAS_DELAY, DAS_RATE);
    localparam logic [CW-1:0] DLY_LAST  = CW'(DAS_DELAY - 1);
    localparam logic [CW-1:0] RATE_LAST = CW'(DAS_RATE - 1);

    logic [NUM_KEYS-1:0] keys_raw;
    logic [NUM_KEYS-1:0] held_lvl;
    logic [NUM_KEYS-1:0] rise;
    logic                lr_conflict;
    logic                enable_q;
    logic                rot_q;

    assign keys_raw = {key_drop, key_rot, key_right, key_left};

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .KEY_ACTIVE_LOW  (KEY_ACTIVE_LOW)
    ) u_db [NUM_KEYS-1:0] (
        .clk     (CLOCK_50),
        .reset   (reset),
        .key_raw (keys_raw),
        .level   (held_lvl),
        .rise    (rise)
    );

    assign lr_conflict = held_lvl[CH_LEFT] && held_lvl[CH_RIGHT];

    // Auto-repeat channels. Dropping to IDLE whenever the key may not fire
    // makes every return of permission (release of the opposing key, enable
    // rising) restart as a fresh press: immediate pulse, then the long delay.
    for (genvar g = 0; g < 3; g++) begin : g_rpt
        localparam int CH = (g == 2) ? CH_DROP : g;

        logic          allow;
        logic          pulse_q;
        rpt_state_e    st;
        logic [CW-1:0] cnt;

        assign allow = enable && held_lvl[CH] && !(lr_conflict && CH != CH_DROP);

        always_ff @(posedge CLOCK_50) begin
            if (reset || !allow) begin
                st      <= RPT_IDLE;
                cnt     <= '0;
                pulse_q <= 1'b0;
            end else if (st == RPT_IDLE || rise[CH]) begin
                st      <= RPT_DELAY;
                cnt     <= '0;
                pulse_q <= 1'b1;
            end else begin
                pulse_q <= 1'b0;
                cnt     <= cnt + 1'b1;
                case (st)
                    RPT_DELAY: begin
                        if (cnt == DLY_LAST) begin
                            st      <= RPT_REPEAT;
                            cnt     <= '0;
                            pulse_q <= 1'b1;
                        end
                    end
                    RPT_REPEAT: begin
                        if (cnt == RATE_LAST) begin
                            cnt     <= '0;
                            pulse_q <= 1'b1;
                        end
                    end
                    default: begin
                        st  <= RPT_IDLE;
                        cnt <= '0;
                    end
                endcase
            end
        end
    end

    // Rotate fires once per press; a key already held when enable rises
    // counts as a new press.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            enable_q <= 1'b0;
            rot_q    <= 1'b0;
        end else begin
            enable_q <= enable;
            rot_q    <= enable && held_lvl[CH_ROT] && (rise[CH_ROT] || !enable_q);
        end
    end

    assign left_final  = g_rpt[0].pulse_q;
    assign right_final = g_rpt[1].pulse_q;
    assign drop_final  = g_rpt[2].pulse_q;
    assign rot_final   = rot_q;
    assign held        = held_lvl;

endmodule

// File: tb/tb_tetris_input_cond.sv
// Scoreboard bench: expected pulse cycles are queued as stimulus is applied
// and every observed pulse is popped and compared against the queue head.
module tb_tetris_input_cond;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic       key_left = 1'b1;
    logic       key_right = 1'b1;
    logic       key_rot = 1'b1;
    logic       key_drop = 1'b1;
    logic       left_final, right_final, rot_final, drop_final;
    logic [3:0] held;
    logic [3:0] pulses;

    typedef struct {
        int         cyc;
        logic [3:0] vec;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    bit   mon_en = 1'b0;

    tetris_input_cond #(
        .DEBOUNCE_CYCLES (4),
        .DAS_DELAY       (10),
        .DAS_RATE        (3),
        .KEY_ACTIVE_LOW  (1)
    ) dut (
        .CLOCK_50    (clk),
        .reset       (reset),
        .enable      (enable),
        .key_left    (key_left),
        .key_right   (key_right),
        .key_rot     (key_rot),
        .key_drop    (key_drop),
        .left_final  (left_final),
        .right_final (right_final),
        .rot_final   (rot_final),
        .drop_final  (drop_final),
        .held        (held)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign pulses = {drop_final, rot_final, right_final, left_final};

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                      tag, got, got, exp, exp, cyc);
    endtask

    task automatic push(input int c, input logic [3:0] v);
        exp_t x;
        x.cyc = c;
        x.vec = v;
        exp_q.push_back(x);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en && pulses != 4'b0000) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", int'(pulses), 0);
            end else begin
                e = exp_q.pop_front();
                chk("pulse_cycle", cyc, e.cyc);
                chk("pulse_chan", int'(pulses), int'(e.vec));
            end
        end
    end

    initial begin
        int c0;

        // Reset held 3 cycles with all keys released
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pulses", int'(pulses), 0);
        chk("rst_held", int'(held), 0);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;
        step(20);
        chk("idle_held", int'(held), 0);

        // Bounce on rotate, then a steady press
        for (int i = 0; i < 8; i++) begin
            key_rot = logic'(i % 2);
            step(2);
        end
        key_rot = 1'b0;
        c0 = cyc;
        push(c0 + 7, 4'b0100);
        step(45);
        chk("bounce_held", int'(held), 4'b0100);
        chk("bounce_pending", exp_q.size(), 0);
        key_rot = 1'b1;
        step(10);
        chk("bounce_release", int'(held), 0);

        // DAS on left: 7, 17, then every 3 until the release is debounced
        key_left = 1'b0;
        c0 = cyc;
        push(c0 + 7, 4'b0001);
        for (int t = 17; t <= 44; t += 3) push(c0 + t, 4'b0001);
        step(40);
        key_left = 1'b1;
        step(7);
        chk("das_release_held", int'(held), 0);
        step(10);
        chk("das_pending", exp_q.size(), 0);

        // Left/right lockout and re-arm of the surviving key
        key_left = 1'b0;
        c0 = cyc;
        push(c0 + 7, 4'b0001);
        for (int t = 17; t <= 26; t += 3) push(c0 + t, 4'b0001);
        step(20);
        key_right = 1'b0;
        step(10);
        chk("conflict_held", int'(held), 4'b0011);
        step(10);
        key_left = 1'b1;
        push(c0 + 47, 4'b0010);
        for (int t = 57; t <= 63; t += 3) push(c0 + t, 4'b0010);
        step(18);
        key_right = 1'b1;
        step(15);
        chk("conflict_held_end", int'(held), 0);
        chk("conflict_pending", exp_q.size(), 0);

        // Enable gate: drop and rotate held while disabled
        enable   = 1'b0;
        key_drop = 1'b0;
        key_rot  = 1'b0;
        step(30);
        chk("gate_held", int'(held), 4'b1100);
        chk("gate_pending", exp_q.size(), 0);
        enable = 1'b1;
        c0 = cyc;
        push(c0 + 1, 4'b1100);
        for (int t = 11; t <= 20; t += 3) push(c0 + t, 4'b1000);
        step(15);
        key_drop = 1'b1;
        key_rot  = 1'b1;
        step(12);
        chk("gate_release", int'(held), 0);
        chk("gate_pending_end", exp_q.size(), 0);

        // Reset in the middle of left auto-repeat
        key_left = 1'b0;
        c0 = cyc;
        push(c0 + 7, 4'b0001);
        push(c0 + 17, 4'b0001);
        push(c0 + 20, 4'b0001);
        step(21);
        reset = 1'b1;
        @(negedge clk);
        chk("rstmid_left_a", int'(left_final), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rstmid_left_b", int'(left_final), 0);
        chk("rstmid_held", int'(held), 0);
        push(c0 + 29, 4'b0001);
        push(c0 + 39, 4'b0001);
        push(c0 + 42, 4'b0001);
        push(c0 + 45, 4'b0001);
        step(18);
        key_left = 1'b1;
        step(15);
        chk("rstmid_release", int'(held), 0);
        chk("rstmid_pending", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/tetris_input_cond.md
Name: tetris_input_cond

Overview:
- Upstream input-conditioning stage for the Tetris game logic.
- Converts raw, bouncy, asynchronous DE1 KEY buttons into clean single-cycle action pulses: left_final, right_final, rot_final and drop_final.
- Left, right and drop get auto-repeat (DAS: delayed auto shift) while held; rotate fires once per press.
- The game logic consumes the pulses directly, one action per pulse.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed to accept a level change (20 ms at 50 MHz).
- DAS_DELAY, 8000000, cycles from the first pulse to the first auto-repeat pulse (160 ms).
- DAS_RATE, 2500000, cycles between subsequent auto-repeat pulses (50 ms).
- KEY_ACTIVE_LOW, 1, 1 = raw key reads 0 when pressed (DE1 KEY); 0 = active-high.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  high = game accepts actions; low = all pulses suppressed.
- key_left  in  1  raw left button, asynchronous.
- key_right  in  1  raw right button, asynchronous.
- key_rot  in  1  raw rotate button, asynchronous.
- key_drop  in  1  raw soft-drop button, asynchronous.
- left_final  out  1  one-cycle move-left pulse.
- right_final  out  1  one-cycle move-right pulse.
- rot_final  out  1  one-cycle rotate pulse.
- drop_final  out  1  one-cycle soft-drop pulse.
- held  out  4  debounced pressed levels {drop, rot, right, left}.

Behaviour:
- Reset: one clock with reset high clears everything.
  - All outputs 0; synchronizers and debounced levels = "released".
  - Counters 0; all repeat FSMs in IDLE.
  - Reset asserted mid-operation aborts any in-progress debounce or repeat; no pulse is issued in the reset cycle or the cycle after it.
- Sync: each key passes through a 2-FF synchronizer, then is normalised to pressed=1 per KEY_ACTIVE_LOW.
- Debounce, per channel:
  - Counter increments while the synced value differs from the debounced level and resets to 0 when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES produces no change.
- Latency: a raw press held steady from cycle 0 sets held[i] at cycle DEBOUNCE_CYCLES+2. The first pulse is high during cycle DEBOUNCE_CYCLES+3, for exactly one cycle.
- Repeat FSM for left, right and drop (states IDLE, DELAY, REPEAT):
  - IDLE -> DELAY on the debounced rising edge; emit pulse; clear counter.
  - DELAY: count; at DAS_DELAY-1 emit pulse, clear counter, go REPEAT.
  - REPEAT: count; at DAS_RATE-1 emit pulse, clear counter, stay.
  - Any state -> IDLE on debounced release; no pulse on release.
- Rotate: pulse only on the debounced rising edge; no repeat FSM.
- Left/right conflict: while both held[0] and held[1] are 1, left_final and right_final are forced 0 and both FSMs are held in IDLE. When one is released, the remaining held key re-arms as a fresh press: immediate pulse, then DAS_DELAY.
- enable low:
  - All *_final forced 0 and all FSMs forced to IDLE.
  - Debounce and held keep operating.
  - On enable rising while a key is held, that key is treated as a fresh press on the next cycle: pulse, then DAS_DELAY. This applies to rot as well.
- Simultaneous pulses on different channels (e.g. rot + drop in the same cycle) are all emitted; the game logic prioritises.
- Counter widths: $clog2 of the largest parameter + 1; no wrap-around is possible because every counter clears at its terminal value.
- All outputs are registered.

Decomposition:
- Shared package tetris_pkg:
  - Repeat-state typedef {RPT_IDLE, RPT_DELAY, RPT_REPEAT}.
  - Channel index constants CH_LEFT=0, CH_RIGHT=1, CH_ROT=2, CH_DROP=3.
  - Default timing constants (DEBOUNCE_CYCLES_50M, DAS_DELAY_50M, DAS_RATE_50M).
- One natural sub-module: key_debounce (synchronizer + stable counter + registered level and rise output), instantiated 4 times.
- Repeat FSMs and conflict/enable logic live in the top.

Test Plan (DEBOUNCE_CYCLES=4, DAS_DELAY=10, DAS_RATE=3, KEY_ACTIVE_LOW=1, enable=1 unless stated):
- Reset: hold reset 3 cycles with all keys at 1 -> all *_final=0, held=4'b0000; no pulse within 20 cycles after release.
- Bounce: key_rot toggles 0/1 every 2 cycles for 16 cycles, then held at 0 -> exactly one rot_final pulse, 7 cycles after the final stable 0; rot_final never repeats while held 40 cycles.
- DAS: key_left=0 held 40 cycles -> left_final pulses at cycles 7, 17, 20, 23, 26, …; release -> pulses stop, held[0]=0 after 7 cycles, no release pulse.
- Conflict: left held to REPEAT, then right pressed -> once held[1]=1, no left/right pulses; release left -> right_final pulses 1 cycle after held[0] falls, then again 10 cycles later.
- Enable gate: drop held with enable=0 for 30 cycles -> drop_final=0 throughout; raise enable -> drop_final pulse next cycle, next pulse 10 cycles later.
- Reset mid-repeat: left in REPEAT, assert reset 1 cycle -> left_final=0 that cycle and the next; key still held -> new first pulse DEBOUNCE_CYCLES+3 cycles after reset deasserts.
